// File: rtl/support_mem_loader_pkg.sv
// rtl/support_mem_loader_pkg.sv - shared state encoding for the support memory loader
package support_mem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BYTE = 2'd1,
        ST_WRITE     = 2'd2,
        ST_FINISH    = 2'd3
    } state_t;

endpackage

// File: rtl/support_mem_loader.sv
// rtl/support_mem_loader.sv - streams bytes into support CPU memory while holding that CPU off the bus
module support_mem_loader
    import support_mem_loader_pkg::*;
#(
    parameter logic [15:0] BASE_DEFAULT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        base_sel,
    input  logic [15:0] base_A,
    input  logic [15:0] length,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        sys_en,
    output logic [15:0] sys_A,
    output logic [7:0]  sys_data,
    output logic        sys_wr,
    output logic        support_hold,
    output logic        busy,
    output logic        done,
    output logic [7:0]  checksum
);

    state_t      state, state_next;
    logic [15:0] addr;
    logic [15:0] last_addr;
    logic [15:0] count;
    logic [7:0]  data;
    logic [7:0]  sum;
    logic        accept;
    logic        capture;

    assign accept  = (state == ST_IDLE) && start && !abort;
    assign capture = (state == ST_WAIT_BYTE) && in_valid && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        sys_wr       = 1'b0;
        done         = 1'b0;
        busy         = 1'b1;
        sys_en       = 1'b1;
        support_hold = 1'b1;
        sys_A        = last_addr;
        sys_data     = data;
        case (state)
            ST_IDLE: begin
                busy         = 1'b0;
                sys_en       = 1'b0;
                support_hold = 1'b0;
                sys_A        = 16'h0000;
                sys_data     = 8'h00;
                if (accept) state_next = (length != 16'h0000) ? ST_WAIT_BYTE : ST_FINISH;
            end
            ST_WAIT_BYTE: begin
                in_ready = 1'b1;
                if (capture) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                sys_wr     = 1'b1;
                sys_A      = addr;
                state_next = (count == 16'h0001) ? ST_FINISH : ST_WAIT_BYTE;
            end
            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Abort overrides every active state; the write strobe above still goes out this cycle.
        if (state != ST_IDLE && abort) state_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= 16'h0000;
            last_addr <= 16'h0000;
            count     <= 16'h0000;
            data      <= 8'h00;
            sum       <= 8'h00;
        end else begin
            if (accept) begin
                addr      <= base_sel ? base_A : BASE_DEFAULT;
                last_addr <= base_sel ? base_A : BASE_DEFAULT;
                count     <= length;
                data      <= 8'h00;
                sum       <= 8'h00;
            end
            if (capture) begin
                data <= in_data;
                sum  <= sum + in_data;
            end
            // last_addr keeps sys_A steady on the most recent write between strobes.
            if (state == ST_WRITE) begin
                addr      <= addr + 16'h0001;
                last_addr <= addr;
                count     <= count - 16'h0001;
            end
        end
    end

    assign checksum = sum;

endmodule

// File: tb/tb_support_mem_loader.sv
// tb/tb_support_mem_loader.sv - randomized self-checking bench for support_mem_loader
module tb_support_mem_loader;

    localparam logic [15:0] BASE_DEF = 16'h0200;

    logic        clk = 1'b0;
    logic        reset, start, abort, base_sel, in_valid;
    logic [15:0] base_a, length;
    logic [7:0]  in_data;
    logic        in_ready, sys_en, sys_wr, support_hold, busy, done;
    logic [15:0] sys_A;
    logic [7:0]  sys_data, checksum;

    int passed = 0;
    int total  = 0;
    int cyc = 0, start_cyc = -1, first_wr_cyc = -1, last_wr_cyc = -1, done_cyc = -1;
    int done_cnt = 0, en_cnt = 0;
    logic [15:0] wr_a_q[$];
    logic [7:0]  wr_d_q[$];

    support_mem_loader #(.BASE_DEFAULT(BASE_DEF)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .base_sel(base_sel),
        .base_A(base_a), .length(length), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sys_en(sys_en), .sys_A(sys_A), .sys_data(sys_data),
        .sys_wr(sys_wr), .support_hold(support_hold), .busy(busy), .done(done),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start && !abort && !busy && !reset) start_cyc = cyc;
        cyc++;
    end

    always @(negedge clk) begin
        if (sys_wr) begin
            wr_a_q.push_back(sys_A);
            wr_d_q.push_back(sys_data);
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (sys_en) en_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        wr_a_q.delete();
        wr_d_q.delete();
        done_cnt = 0; en_cnt = 0;
        start_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
    endtask

    // Reference: writes land at base+i (mod 2^16) with the i-th byte; checksum is the mod-256 sum.
    task automatic run_load(input string tag, input logic bsel, input logic [15:0] ba, input int len,
                            input int gap, input logic rand_gap, input logic poke);
        logic [7:0]  bytes[$];
        logic [15:0] base;
        logic [7:0]  sum;
        int t, g;
        base = bsel ? ba : BASE_DEF;
        sum  = 8'h00;
        for (int i = 0; i < len; i++) begin
            bytes.push_back(8'($urandom));
            sum += bytes[i];
        end
        clear_mon();
        @(negedge clk);
        start = 1'b1; base_sel = bsel; base_a = ba; length = 16'(len);
        @(negedge clk);
        start = 1'b0; base_a = 16'($urandom); length = 16'($urandom); base_sel = ~bsel;
        for (int i = 0; i < len; i++) begin
            g = rand_gap ? int'($urandom_range(0, gap)) : gap;
            in_valid = 1'b0;
            if (poke && i == len - 1) begin
                start = 1'b1; base_a = ~ba; length = 16'd9; base_sel = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            repeat (g) @(negedge clk);
            if (!rand_gap && g >= 2) begin
                check({tag, "_gap_ready"}, 32'(in_ready), 32'd1);
                check({tag, "_gap_nowr"}, 32'(sys_wr), 32'd0);
                if (i > 0) begin
                    check({tag, "_hold_A"}, 32'(sys_A), 32'(16'(base + 16'(i - 1))));
                    check({tag, "_hold_D"}, 32'(sys_data), 32'(bytes[i-1]));
                end
            end
            in_valid = 1'b1; in_data = bytes[i];
            t = 0;
            while (!in_ready && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
        end
        t = 0;
        while (busy && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check({tag, "_busy_timeout"}, 32'(busy), 32'd0);
        @(negedge clk); #1;
        check({tag, "_nwr"}, 32'(wr_a_q.size()), 32'(len));
        for (int i = 0; i < len && i < wr_a_q.size(); i++) begin
            check({tag, "_addr"}, 32'(wr_a_q[i]), 32'(16'(base + 16'(i))));
            check({tag, "_data"}, 32'(wr_d_q[i]), 32'(bytes[i]));
        end
        check({tag, "_checksum"}, 32'(checksum), 32'(sum));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_idle_A"}, 32'(sys_A), 32'd0);
        if (!rand_gap && gap == 0 && len > 0) begin
            check({tag, "_first_lat"}, 32'(first_wr_cyc - start_cyc), 32'd2);
            check({tag, "_rate"}, 32'(last_wr_cyc - first_wr_cyc), 32'(2 * (len - 1)));
        end
        if (len == 0) begin
            check({tag, "_en_cycles"}, 32'(en_cnt), 32'd1);
            check({tag, "_done_lat"}, 32'(done_cyc - start_cyc), 32'd1);
        end
    endtask

    initial begin
        logic [7:0] b0;
        int t;
        reset = 1'b1; start = 1'b0; abort = 1'b0; base_sel = 1'b0; in_valid = 1'b0;
        base_a = 16'h0; length = 16'h0; in_data = 8'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'(sys_en), 32'd0);
        check("rst_hold", 32'(support_hold), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        check("rst_A", 32'(sys_A), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_load("basic", 1'b1, 16'h1000, 3, 0, 1'b0, 1'b0);
        run_load("wrap", 1'b1, 16'hFFFF, 2, 0, 1'b0, 1'b0);
        run_load("len0", 1'b1, 16'h4321, 0, 0, 1'b0, 1'b0);
        run_load("dflt", 1'b0, 16'hABCD, 2, 0, 1'b0, 1'b0);
        run_load("gap5", 1'b1, 16'h3000, 3, 5, 1'b0, 1'b0);
        run_load("busy_start", 1'b1, 16'h5000, 3, 1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++)
            run_load("rand", 1'($urandom), 16'($urandom), int'($urandom_range(1, 6)), 3, 1'b1, 1'b0);

        // abort after the first of four bytes
        clear_mon();
        b0 = 8'($urandom);
        @(negedge clk);
        start = 1'b1; base_sel = 1'b1; base_a = 16'h7000; length = 16'd4;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk); #1;
        check("abort_nwr", 32'(wr_a_q.size()), 32'd1);
        if (wr_a_q.size() > 0) check("abort_addr", 32'(wr_a_q[0]), 32'h7000);
        check("abort_done", 32'(done_cnt), 32'd0);
        check("abort_checksum", 32'(checksum), 32'(b0));

        // start and abort together in IDLE
        clear_mon();
        @(negedge clk);
        start = 1'b1; abort = 1'b1; length = 16'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("startabort_busy", 32'(busy), 32'd0);
        @(negedge clk); #1;
        check("startabort_en", 32'(en_cnt), 32'd0);

        // asynchronous reset during WRITE
        clear_mon();
        @(negedge clk);
        start = 1'b1; base_sel = 1'b1; base_a = 16'h2000; length = 16'd3;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        t = 0;
        while (!sys_wr && t < 20) begin @(negedge clk); t++; end
        check("rstw_reached_write", 32'(sys_wr), 32'd1);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rstw_en", 32'(sys_en), 32'd0);
        check("rstw_wr", 32'(sys_wr), 32'd0);
        check("rstw_hold", 32'(support_hold), 32'd0);
        start = 1'b1; length = 16'd2;
        repeat (2) @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_checksum", 32'(checksum), 32'd0);
        check("rstw_A", 32'(sys_A), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/support_mem_loader.md
SUPPORT_MEM_LOADER -- requirements
Module: support_mem_loader

Interface
REQ-001 SHALL have parameter BASE_DEFAULT, default 16'h0000, load start address used when base_sel=0.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-005 SHALL have port abort  input  1  terminate any load in progress.
REQ-006 SHALL have port base_sel  input  1  1: use base_A; 0: use BASE_DEFAULT.
REQ-007 SHALL have port base_A  input  16  load start address, sampled on accepted start.
REQ-008 SHALL have port length  input  16  byte count, sampled on accepted start; 0 means no writes.
REQ-009 SHALL have port in_data  input  8  stream byte.
REQ-010 SHALL have port in_valid  input  1  in_data valid.
REQ-011 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-012 SHALL have port sys_en  output  1  takes memory port from the support CPU.
REQ-013 SHALL have port sys_A  output  16  memory write address.
REQ-014 SHALL have port sys_data  output  8  memory write data.
REQ-015 SHALL have port sys_wr  output  1  memory write strobe.
REQ-016 SHALL have port support_hold  output  1  holds the support CPU in reset/wait.
REQ-017 SHALL have port busy  output  1  load in progress.
REQ-018 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-019 SHALL have port checksum  output  8  mod-256 sum of bytes accepted since last start.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT_BYTE, WRITE, FINISH; outputs decoded from state and registers only (Moore).
REQ-021 IDLE: on start=1 and abort=0, latch address (base_A or BASE_DEFAULT), latch length into count, clear checksum; go WAIT_BYTE if length!=0, else FINISH.
REQ-022 WAIT_BYTE: in_ready=1; on in_valid=1 capture in_data into data register, add to checksum, go WRITE; otherwise remain.
REQ-023 WRITE: sys_wr=1 for exactly one cycle with sys_A=current address, sys_data=captured byte; at cycle end address+1 (16'hFFFF wraps to 16'h0000), count-1; go FINISH if count was 1, else WAIT_BYTE.
REQ-024 FINISH: done=1 for exactly one cycle, then IDLE.
REQ-025 sys_en=1 and support_hold=1 in WAIT_BYTE, WRITE, FINISH; both 0 in IDLE.
REQ-026 busy=1 in every state except IDLE.
REQ-027 in_ready SHALL be 0 in every state except WAIT_BYTE; sys_wr SHALL be 0 in every state except WRITE.
REQ-028 Throughput SHALL be one byte per two clocks with in_valid held high; first write occurs two cycles after start.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with no done pulse; a write already presented in WRITE completes that cycle.
REQ-031 start and abort both high in IDLE: abort wins, state stays IDLE.
REQ-032 checksum SHALL hold its value after done or abort until the next accepted start.
REQ-033 sys_A and sys_data SHALL hold last values when not writing; in IDLE, sys_A and sys_data are 0.

Reset
REQ-034 reset SHALL asynchronously force IDLE, address=0, count=0, data=0, checksum=0; all outputs 0.
REQ-035 reset mid-load SHALL drop sys_en and support_hold immediately, without waiting for clk.

Structure
REQ-036 State encoding constants SHALL reside in the shared package; all logic SHALL stay in a single module with no sub-module.

Verification
REQ-037 base_sel=1, base_A=16'h1000, length=3, bytes 11,22,33 -> writes at 1000/1001/1002, checksum 8'h66, one done pulse.
REQ-038 base_A=16'hFFFF, length=2, bytes AA,55 -> writes at FFFF then 0000, checksum 8'hFF.
REQ-039 length=0 start -> no sys_wr, sys_en high one cycle, done pulses one cycle after start.
REQ-040 abort after first of 4 bytes -> exactly one write, busy low next cycle, no done, checksum held.
REQ-041 in_valid gapped 5 cycles between bytes -> in_ready held, sys_wr only after each handshake, no extra writes.
REQ-042 reset asserted asynchronously in WRITE -> sys_en, sys_wr, support_hold low before next clk edge; start ignored during reset.
